pdm_capture_ctrl: RTL and testbench
===================================

PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
  DEPTH_LOG2, 9, log2 of sample buffer depth (DEPTH = 2^DEPTH_LOG2 entries)
  WIDTH, 16, PCM sample width
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock
  rst  in  1  synchronous, active-high reset
  start  in  1  one-cycle pulse; begin capture session
  stop  in  1  one-cycle pulse; end capture session
  warmup  in  8  samples to discard after start (CIC settling)
  frame_len  in  DEPTH_LOG2  samples per frame; 0 means DEPTH
  mic_enable  out  1  enable to PDM microphone front end
  pcm_in  in  WIDTH  sample from microphone front end
  pcm_in_valid  in  1  one-cycle pulse qualifying pcm_in
  rd_en  in  1  pop request from CPU/DMA side
  rd_data  out  WIDTH  popped sample
  rd_valid  out  1  rd_data valid (one-cycle pulse)
  level  out  DEPTH_LOG2+1  buffered sample count, 0..DEPTH
  frame_irq  out  1  sticky frame-complete interrupt
  overflow  out  1  sticky dropped-sample flag
  status_clear  in  1  clears frame_irq and overflow
  state  out  2  FSM state: 0 IDLE, 1 WARMUP, 2 CAPTURE
REQ-003 Reset: rst, synchronous, active-high; clock clk; all logic on rising edge of clk.

Function
REQ-004 FSM SHALL have states IDLE, WARMUP, CAPTURE; state 3 unreachable, decoded as IDLE.
REQ-005 IDLE + start: latch warmup and frame_len, clear buffer pointers, level and frame counter; go WARMUP if warmup!=0, else CAPTURE; overflow/frame_irq untouched.
REQ-006 start in WARMUP or CAPTURE SHALL be ignored.
REQ-007 stop in WARMUP or CAPTURE SHALL go IDLE next cycle; buffer contents and level retained; stop and start same cycle: stop wins.
REQ-008 WARMUP: each pcm_in_valid decrements remaining count, sample discarded; on decrement to 0 go CAPTURE; no buffer writes in WARMUP.
REQ-009 pcm_in_valid in IDLE, or in the cycle start is accepted, SHALL be ignored.
REQ-010 mic_enable SHALL be registered, 1 iff state is WARMUP or CAPTURE.
REQ-011 CAPTURE: pcm_in_valid writes pcm_in to buffer tail if level<DEPTH or a pop occurs the same cycle; otherwise sample dropped and overflow set.
REQ-012 Frame counter SHALL increment only on accepted writes; reaching latched frame_len (0 = DEPTH) sets frame_irq and resets counter to 0; dropped samples not counted.
REQ-013 rd_en with level>0: pop head, rd_data/rd_valid registered, valid 1 cycle after rd_en; rd_en with level 0: ignored, rd_valid 0, rd_data holds.
REQ-014 Reads SHALL be honoured in every state.
REQ-015 level: +1 write only, -1 pop only, unchanged on write+pop or neither; never exceeds DEPTH or goes below 0.
REQ-016 Buffer pointers SHALL wrap modulo DEPTH.
REQ-017 status_clear clears frame_irq and overflow; same-cycle set event wins (flag stays 1).
REQ-018 Samples read out SHALL be in arrival order with no duplication.

Reset
REQ-019 rst SHALL force state IDLE, mic_enable 0, level 0, pointers 0, frame counter 0, frame_irq 0, overflow 0, rd_data 0, rd_valid 0; rst mid-session aborts capture, discards buffer.
REQ-020 rst SHALL take priority over all other inputs.

Verification (DEPTH_LOG2=4)
REQ-021 Assert rst 2 cycles with random inputs -> all outputs 0, state 0.
REQ-022 warmup=3, frame_len=4, start, samples 1..11 -> values 1..3 discarded, frame_irq set on write of 7, level 8, reads return 4..11 in order.
REQ-023 warmup=0, frame_len=0, 20 samples, no reads -> level 16, overflow 1, frame_irq 1, reads return first 16 samples.
REQ-024 Full buffer, pcm_in_valid and rd_en same cycle -> level stays 16, overflow stays 0, new sample appears last.
REQ-025 stop during WARMUP after 1 of 3 samples -> state 0 and mic_enable 0 next cycle, later samples not written, level 0.
REQ-026 status_clear in same cycle as frame completion -> frame_irq remains 1; status_clear alone next cycle -> 0.

Source files
------------

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl
// ----------------
// Capture controller for a PDM microphone path. After a start pulse it enables
// the microphone, discards a programmable number of warm-up samples while the
// CIC decimator settles, then stores PCM samples in a circular buffer that the
// CPU/DMA side drains with rd_en. A sticky interrupt flags each completed frame
// and a sticky flag records samples dropped because the buffer was full.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start, stop      one-cycle session control pulses (stop wins over start)
//   warmup           samples to discard after start, latched at start
//   frame_len        samples per frame, latched at start (0 means DEPTH)
//   mic_enable       registered enable to the microphone front end
//   pcm_in/_valid    sample stream from the front end
//   rd_en            pop request; rd_data/rd_valid follow one cycle later
//   level            buffered sample count, 0..DEPTH
//   frame_irq        sticky frame-complete flag
//   overflow         sticky dropped-sample flag
//   status_clear     clears frame_irq and overflow (a same-cycle set wins)
//   state            0 IDLE, 1 WARMUP, 2 CAPTURE

module pdm_capture_ctrl #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [7:0]            warmup,
    input  logic [DEPTH_LOG2-1:0] frame_len,
    output logic                  mic_enable,
    input  logic [WIDTH-1:0]      pcm_in,
    input  logic                  pcm_in_valid,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  frame_irq,
    output logic                  overflow,
    input  logic                  status_clear,
    output logic [1:0]            state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic                  mic_en_q,    mic_en_d;
    logic [7:0]            warm_cnt_q,  warm_cnt_d;
    logic [DEPTH_LOG2-1:0] frame_len_q, frame_len_d;
    logic [DEPTH_LOG2:0]   frame_cnt_q, frame_cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,    wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q,    rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q,     level_d;
    logic [WIDTH-1:0]      rd_data_q,   rd_data_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic                  irq_q,       irq_d;
    logic                  ovf_q,       ovf_d;

    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  pop;
    logic                  wr;
    logic                  session_init;
    logic                  irq_set;
    logic                  ovf_set;
    logic [DEPTH_LOG2:0]   frame_target;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        frame_len_d  = frame_len_q;
        frame_cnt_d  = frame_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        wr           = 1'b0;
        session_init = 1'b0;
        irq_set      = 1'b0;
        ovf_set      = 1'b0;

        // Reads are serviced in every state, including the start cycle.
        pop = rd_en && (level_q != '0);

        case (state_q)
            ST_WARMUP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pcm_in_valid) begin
                    warm_cnt_d = warm_cnt_q - 8'd1;
                    if (warm_cnt_q == 8'd1) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                // A sample arriving with stop is not stored: the session ends this cycle.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pcm_in_valid) begin
                    // A same-cycle pop frees the slot the new sample needs.
                    if ((level_q != LEVEL_FULL) || pop) begin
                        wr = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE, and the unreachable encoding 3 treated as IDLE.
                if (start && !stop) begin
                    session_init = 1'b1;
                    warm_cnt_d   = warmup;
                    frame_len_d  = frame_len;
                    state_d      = (warmup != 8'd0) ? ST_WARMUP : ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({wr, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        frame_target = (frame_len_q == '0) ? LEVEL_FULL : {1'b0, frame_len_q};
        if (wr) begin
            if (frame_cnt_q + 1'b1 == frame_target) begin
                frame_cnt_d = '0;
                irq_set     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // A new session starts with an empty buffer; a pop in the same cycle
        // still returns the old head but does not survive the clear.
        if (session_init) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            frame_cnt_d = '0;
        end

        irq_d    = (irq_q && !status_clear) || irq_set;
        ovf_d    = (ovf_q && !status_clear) || ovf_set;
        mic_en_d = (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= ST_IDLE;
            mic_en_q    <= 1'b0;
            warm_cnt_q  <= '0;
            frame_len_q <= '0;
            frame_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mic_en_q    <= mic_en_d;
            warm_cnt_q  <= warm_cnt_d;
            frame_len_q <= frame_len_d;
            frame_cnt_q <= frame_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            irq_q       <= irq_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: the sample store is not reset; level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem[wr_ptr_q] <= pcm_in;
        end
    end

    assign state      = state_q;
    assign mic_enable = mic_en_q;
    assign level      = level_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_irq  = irq_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl
// Directed bench for pdm_capture_ctrl with a 16-entry buffer. Inputs change
// 1 time unit after each rising edge and outputs are sampled at that point.

module tb_pdm_capture_ctrl;

    localparam int DL = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [7:0]    warmup;
    logic [DL-1:0] frame_len;
    logic          mic_enable;
    logic [W-1:0]  pcm_in;
    logic          pcm_in_valid;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [DL:0]   level;
    logic          frame_irq;
    logic          overflow;
    logic          status_clear;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    pdm_capture_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .warmup       (warmup),
        .frame_len    (frame_len),
        .mic_enable   (mic_enable),
        .pcm_in       (pcm_in),
        .pcm_in_valid (pcm_in_valid),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .level        (level),
        .frame_irq    (frame_irq),
        .overflow     (overflow),
        .status_clear (status_clear),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        pcm_in       = v;
        pcm_in_valid = 1'b1;
        tick();
        pcm_in_valid = 1'b0;
    endtask

    task automatic begin_session(input logic [7:0] wu, input logic [DL-1:0] fl);
        warmup    = wu;
        frame_len = fl;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic end_session();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start        = 1'($urandom);
            stop         = 1'($urandom);
            warmup       = 8'($urandom);
            frame_len    = DL'($urandom);
            pcm_in       = W'($urandom);
            pcm_in_valid = 1'($urandom);
            rd_en        = 1'($urandom);
            status_clear = 1'($urandom);
            tick();
        end
        checks++;
        if ({state, mic_enable, level, frame_irq, overflow, rd_data, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d mic=%0b level=%0d irq=%0b ovf=%0b rd_data=%0d rd_valid=%0b, expected all 0",
                     state, mic_enable, level, frame_irq, overflow, rd_data, rd_valid);
        end
        {start, stop, pcm_in_valid, rd_en, status_clear} = '0;
        rst = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || level !== '0) begin
            errors++;
            $display("FAIL reset_release: state=%0d level=%0d, expected 0 0", state, level);
        end
    endtask

    task automatic test_warmup_frame();
        begin_session(8'd3, 4'd4);
        checks++;
        if (state !== 2'd1 || mic_enable !== 1'b1) begin
            errors++;
            $display("FAIL warmup_entry: state=%0d mic=%0b, expected 1 1", state, mic_enable);
        end
        for (int v = 1; v <= 11; v++) begin
            push(W'(v));
            if (v == 3) begin
                checks++;
                if (state !== 2'd2 || level !== '0) begin
                    errors++;
                    $display("FAIL warmup_done: state=%0d level=%0d, expected 2 0", state, level);
                end
            end
            if (v == 6 || v == 7) begin
                checks++;
                if (frame_irq !== (v == 7)) begin
                    errors++;
                    $display("FAIL frame_irq_at_%0d: got %0b expected %0b", v, frame_irq, (v == 7));
                end
            end
        end
        checks++;
        if (level !== 5'd8) begin
            errors++;
            $display("FAIL warmup_level: got %0d expected 8", level);
        end
        for (int e = 4; e <= 11; e++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== W'(e)) begin
                errors++;
                $display("FAIL warmup_read: valid=%0b data=%0d, expected 1 %0d", rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== W'(11) || level !== '0) begin
            errors++;
            $display("FAIL empty_read: valid=%0b data=%0d level=%0d, expected 0 11 0", rd_valid, rd_data, level);
        end
        end_session();
        checks++;
        if (state !== 2'd0 || mic_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_capture: state=%0d mic=%0b, expected 0 0", state, mic_enable);
        end
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        checks++;
        if (frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %0b expected 0", frame_irq);
        end
    endtask

    task automatic test_overflow_full();
        begin_session(8'd0, 4'd0);
        checks++;
        if (state !== 2'd2 || mic_enable !== 1'b1) begin
            errors++;
            $display("FAIL direct_capture: state=%0d mic=%0b, expected 2 1", state, mic_enable);
        end
        for (int i = 0; i < 20; i++) push(W'(100 + i));
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL overflow_fill: level=%0d ovf=%0b irq=%0b, expected 16 1 1", level, overflow, frame_irq);
        end
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL status_clear_full: ovf=%0b irq=%0b, expected 0 0", overflow, frame_irq);
        end
        pcm_in       = W'(200);
        pcm_in_valid = 1'b1;
        rd_en        = 1'b1;
        tick();
        pcm_in_valid = 1'b0;
        rd_en        = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== W'(100) || level !== 5'd16 || overflow !== 1'b0 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: valid=%0b data=%0d level=%0d ovf=%0b irq=%0b, expected 1 100 16 0 0",
                     rd_valid, rd_data, level, overflow, frame_irq);
        end
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== ((i == 16) ? W'(200) : W'(100 + i))) begin
                errors++;
                $display("FAIL full_read_%0d: valid=%0b data=%0d, expected 1 %0d",
                         i, rd_valid, rd_data, (i == 16) ? 200 : 100 + i);
            end
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL full_drain_level: got %0d expected 0", level);
        end
        end_session();
    endtask

    task automatic test_stop_warmup();
        begin_session(8'd3, 4'd4);
        push(W'(1));
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL warmup_hold: state=%0d expected 1", state);
        end
        end_session();
        checks++;
        if (state !== 2'd0 || mic_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_warmup: state=%0d mic=%0b, expected 0 0", state, mic_enable);
        end
        for (int i = 2; i <= 4; i++) push(W'(i));
        checks++;
        if (level !== '0 || state !== 2'd0) begin
            errors++;
            $display("FAIL stop_warmup_after: level=%0d state=%0d, expected 0 0", level, state);
        end
    endtask

    task automatic test_start_stop_priority();
        begin_session(8'd0, 4'd0);
        push(W'(5));
        push(W'(6));
        begin_session(8'd3, 4'd2);
        checks++;
        if (state !== 2'd2 || level !== 5'd2) begin
            errors++;
            $display("FAIL start_ignored: state=%0d level=%0d, expected 2 2", state, level);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (state !== 2'd0 || level !== 5'd2 || mic_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_wins: state=%0d level=%0d mic=%0b, expected 0 2 0", state, level, mic_enable);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== W'(5) || level !== 5'd1) begin
            errors++;
            $display("FAIL idle_read: valid=%0b data=%0d level=%0d, expected 1 5 1", rd_valid, rd_data, level);
        end
        push(W'(9));
        checks++;
        if (level !== 5'd1) begin
            errors++;
            $display("FAIL idle_sample: level=%0d expected 1", level);
        end
        pcm_in_valid = 1'b1;
        pcm_in       = W'(77);
        begin_session(8'd0, 4'd0);
        pcm_in_valid = 1'b0;
        checks++;
        if (state !== 2'd2 || level !== '0) begin
            errors++;
            $display("FAIL start_cycle_sample: state=%0d level=%0d, expected 2 0", state, level);
        end
        end_session();
    endtask

    task automatic test_status_clear();
        begin_session(8'd0, 4'd2);
        push(W'(1));
        status_clear = 1'b1;
        push(W'(2));
        status_clear = 1'b0;
        checks++;
        if (frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got %0b expected 1", frame_irq);
        end
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        checks++;
        if (frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear_alone: got %0b expected 0", frame_irq);
        end
        end_session();
    endtask

    task automatic test_reset_mid_session();
        begin_session(8'd0, 4'd0);
        for (int i = 0; i < 3; i++) push(W'(50 + i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state !== 2'd0 || level !== '0 || mic_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d level=%0d mic=%0b, expected 0 0 0", state, level, mic_enable);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: valid=%0b data=%0d, expected 0 0", rd_valid, rd_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        {start, stop, pcm_in_valid, rd_en, status_clear} = '0;
        warmup    = '0;
        frame_len = '0;
        pcm_in    = '0;
        test_reset();
        test_warmup_frame();
        test_overflow_full();
        test_stop_warmup();
        test_start_stop_priority();
        test_status_clear();
        test_reset_mid_session();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
